// File: rtl/seq_alu.sv
// seq_alu: handshaked sequential ALU with an iterative shifter.
//
// Accepts one op at a time through in_valid/in_ready. Non-shift ops and
// zero-distance shifts are computed on the accept edge and show up one cycle
// later. Shifts by a non-zero amount walk the operand SHIFT_STEP bits per cycle
// in the SHIFT state. The result is held in DONE until out_ready retires it.
//
// Ports:
//   clk       in   clock, rising edge
//   reset     in   synchronous active-high reset
//   in_valid  in   request valid
//   in_ready  out  request can be accepted (IDLE only)
//   op        in   [3:0] op code, sampled on accept
//   a, b      in   [XLEN-1:0] operands, sampled on accept
//   out_valid out  result valid (DONE only)
//   out_ready in   consumer takes the result
//   result    out  [XLEN-1:0] registered result
//   busy      out  high in SHIFT or DONE
module seq_alu #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned ShW  = $clog2(XLEN);
  localparam int unsigned CntW = ShW + 1;

  localparam logic [3:0] OpAdd  = 4'b0000;
  localparam logic [3:0] OpSub  = 4'b0001;
  localparam logic [3:0] OpAnd  = 4'b0010;
  localparam logic [3:0] OpOr   = 4'b0011;
  localparam logic [3:0] OpXor  = 4'b0100;
  localparam logic [3:0] OpSll  = 4'b0101;
  localparam logic [3:0] OpSrl  = 4'b0110;
  localparam logic [3:0] OpSra  = 4'b0111;
  localparam logic [3:0] OpSlt  = 4'b1000;
  localparam logic [3:0] OpSltu = 4'b1001;
  localparam logic [3:0] OpPass = 4'b1010;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e          state_q, state_d;
  logic [3:0]      op_q, op_d;
  logic [XLEN-1:0] work_q, work_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [CntW-1:0] rem_q, rem_d;

  logic [ShW-1:0]  shamt;
  logic            is_shift;
  logic [XLEN-1:0] alu_res;
  logic [CntW-1:0] step;
  logic [XLEN-1:0] shifted;

  assign shamt    = b[ShW-1:0];
  assign is_shift = (op == OpSll) || (op == OpSrl) || (op == OpSra);

  // Single-cycle results; shift ops land here only for shamt == 0.
  always_comb begin
    alu_res = '0;
    case (op)
      OpAdd:  alu_res = a + b;
      OpSub:  alu_res = a - b;
      OpAnd:  alu_res = a & b;
      OpOr:   alu_res = a | b;
      OpXor:  alu_res = a ^ b;
      OpSll,
      OpSrl,
      OpSra:  alu_res = a;
      OpSlt:  alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      OpSltu: alu_res = {{(XLEN-1){1'b0}}, a < b};
      OpPass: alu_res = b;
      default: alu_res = '0;
    endcase
  end

  // Per-cycle distance is min(SHIFT_STEP, remaining).
  assign step = (rem_q > CntW'(SHIFT_STEP)) ? CntW'(SHIFT_STEP) : rem_q;

  // The arithmetic shift keeps the MSB of the working register, which is the
  // original a[XLEN-1] for the whole operation.
  always_comb begin
    shifted = work_q;
    case (op_q)
      OpSll:   shifted = work_q << step;
      OpSrl:   shifted = work_q >> step;
      default: shifted = $unsigned($signed(work_q) >>> step);
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    work_d   = work_q;
    rem_d    = rem_q;
    result_d = result_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_d = op;
          if (is_shift && (shamt != '0)) begin
            work_d  = a;
            rem_d   = {1'b0, shamt};
            state_d = StShift;
          end else begin
            result_d = alu_res;
            state_d  = StDone;
          end
        end
      end
      StShift: begin
        work_d = shifted;
        rem_d  = rem_q - step;
        if (rem_q == step) begin
          result_d = shifted;
          state_d  = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      op_q     <= '0;
      work_q   <= '0;
      rem_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      work_q   <= work_d;
      rem_q    <= rem_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign result    = result_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: three instances (32-bit step 1, 32-bit step 8,
// 64-bit step 1) share clock, reset, operands and out_ready.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  iv;
  logic [2:0]  ir, ov, bz;
  logic        out_ready;
  logic [3:0]  op_d;
  logic [63:0] a_d, b_d;
  logic [31:0] res0, res1;
  logic [63:0] res2;
  logic [63:0] res_m [3];

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [63:0] exp;
    int          lat;
    string       tag;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  assign res_m[0] = {32'h0, res0};
  assign res_m[1] = {32'h0, res1};
  assign res_m[2] = res2;

  seq_alu #(.XLEN(32), .SHIFT_STEP(1)) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]), .op(op_d),
    .a(a_d[31:0]), .b(b_d[31:0]), .out_valid(ov[0]), .out_ready(out_ready),
    .result(res0), .busy(bz[0])
  );

  seq_alu #(.XLEN(32), .SHIFT_STEP(8)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]), .op(op_d),
    .a(a_d[31:0]), .b(b_d[31:0]), .out_valid(ov[1]), .out_ready(out_ready),
    .result(res1), .busy(bz[1])
  );

  seq_alu #(.XLEN(64), .SHIFT_STEP(1)) u_dut2 (
    .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]), .op(op_d),
    .a(a_d), .b(b_d), .out_valid(ov[2]), .out_ready(out_ready),
    .result(res2), .busy(bz[2])
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int width_of(input int sel);
    return (sel == 2) ? 64 : 32;
  endfunction

  function automatic int step_of(input int sel);
    return (sel == 1) ? 8 : 1;
  endfunction

  // Reference result using native operators at width w.
  function automatic logic [63:0] model(input int w, input logic [3:0] o,
                                        input logic [63:0] av, input logic [63:0] bv);
    logic [63:0]        mask, am, bm, r;
    logic signed [63:0] as, bs;
    int                 sh;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    am   = av & mask;
    bm   = bv & mask;
    as   = (w == 64) ? av : {{32{av[31]}}, av[31:0]};
    bs   = (w == 64) ? bv : {{32{bv[31]}}, bv[31:0]};
    sh   = (w == 64) ? int'(bv[5:0]) : int'(bv[4:0]);
    case (o)
      4'd0:    r = am + bm;
      4'd1:    r = am - bm;
      4'd2:    r = am & bm;
      4'd3:    r = am | bm;
      4'd4:    r = am ^ bm;
      4'd5:    r = am << sh;
      4'd6:    r = am >> sh;
      4'd7:    r = as >>> sh;
      4'd8:    r = {63'h0, as < bs};
      4'd9:    r = {63'h0, am < bm};
      4'd10:   r = bm;
      default: r = 64'h0;
    endcase
    return r & mask;
  endfunction

  function automatic int lat_of(input int w, input int step, input logic [3:0] o,
                                input logic [63:0] bv);
    int sh;
    sh = (w == 64) ? int'(bv[5:0]) : int'(bv[4:0]);
    if ((o >= 4'd5) && (o <= 4'd7) && (sh != 0)) return 1 + (sh + step - 1) / step;
    return 1;
  endfunction

  // Issue one op on instance sel; hold keeps out_ready low for 5 cycles in DONE
  // while pulsing in_valid, which must be ignored.
  task automatic run_op(input int sel, input logic [3:0] o, input logic [63:0] av,
                        input logic [63:0] bv, input logic [63:0] exp, input bit hold,
                        input string tag);
    exp_t it;
    int   n;
    @(negedge clk);
    check_eq({tag, ".in_ready"}, 64'(ir[sel]), 64'd1);
    op_d      = o;
    a_d       = av;
    b_d       = bv;
    iv[sel]   = 1'b1;
    out_ready = !hold;
    @(posedge clk);
    it.exp = exp;
    it.lat = lat_of(width_of(sel), step_of(sel), o, bv);
    it.tag = tag;
    sb_q.push_back(it);
    #1;
    iv[sel] = 1'b0;
    op_d    = 4'($urandom);
    a_d     = {$urandom, $urandom};
    b_d     = {$urandom, $urandom};
    n = 1;
    while (!ov[sel] && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    it = sb_q.pop_front();
    if (!ov[sel]) begin
      check_eq({tag, ".timeout"}, 64'd0, 64'd1);
      return;
    end
    check_eq({tag, ".result"}, res_m[sel], it.exp);
    check_eq({tag, ".latency"}, 64'(n), 64'(it.lat));
    check_eq({tag, ".busy"}, 64'(bz[sel]), 64'd1);
    check_eq({tag, ".rdy_low"}, 64'(ir[sel]), 64'd0);
    if (hold) begin
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        iv[sel] = 1'b1;
        op_d    = 4'd0;
        a_d     = {$urandom, $urandom};
        b_d     = {$urandom, $urandom};
        @(posedge clk);
        #1;
        check_eq({tag, ".bp_valid"}, 64'(ov[sel]), 64'd1);
        check_eq({tag, ".bp_rdy"}, 64'(ir[sel]), 64'd0);
        check_eq({tag, ".bp_stable"}, res_m[sel], it.exp);
      end
      @(negedge clk);
      iv[sel]   = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check_eq({tag, ".idle_rdy"}, 64'(ir[sel]), 64'd1);
    check_eq({tag, ".idle_valid"}, 64'(ov[sel]), 64'd0);
    check_eq({tag, ".kept"}, res_m[sel], it.exp);
  endtask

  task automatic run_rand(input int sel, input int count);
    logic [3:0]  o;
    logic [63:0] av, bv;
    for (int i = 0; i < count; i++) begin
      o  = 4'($urandom_range(0, 15));
      av = {$urandom, $urandom};
      bv = {$urandom, $urandom};
      if (width_of(sel) == 32) begin
        av[63:32] = 32'h0;
        bv[63:32] = 32'h0;
      end
      run_op(sel, o, av, bv, model(width_of(sel), o, av, bv), 1'b0, $sformatf("rnd%0d_%0d", sel, i));
    end
  endtask

  initial begin
    int stale;
    reset     = 1'b1;
    iv        = 3'b000;
    out_ready = 1'b1;
    op_d      = 4'd0;
    a_d       = 64'h0;
    b_d       = 64'h0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      check_eq("rst.in_ready", 64'(ir[s]), 64'd1);
      check_eq("rst.out_valid", 64'(ov[s]), 64'd0);
      check_eq("rst.busy", 64'(bz[s]), 64'd0);
      check_eq("rst.result", res_m[s], 64'd0);
    end
    @(negedge clk);
    reset = 1'b0;

    run_op(0, 4'b0000, 64'h7FFF_FFFF, 64'h1, 64'h8000_0000, 1'b0, "add_wrap");
    run_op(0, 4'b0001, 64'h0, 64'h1, 64'hFFFF_FFFF, 1'b0, "sub_wrap");
    run_op(0, 4'b0111, 64'h8000_0000, 64'd31, 64'hFFFF_FFFF, 1'b0, "sra31_s1");
    run_op(0, 4'b1000, 64'hFFFF_FFFF, 64'h1, 64'h1, 1'b0, "slt");
    run_op(0, 4'b1001, 64'hFFFF_FFFF, 64'h1, 64'h0, 1'b0, "sltu");
    run_op(0, 4'b1111, 64'h1234_5678, 64'h9ABC_DEF0, 64'h0, 1'b0, "op1111");
    run_op(0, 4'b0101, 64'hA5A5_0001, 64'd4, 64'h5A50_0010, 1'b0, "sll4");
    run_op(0, 4'b0000, 64'h1234_5678, 64'h1111_1111, 64'h2345_6789, 1'b1, "bp_add");
    run_rand(0, 16);

    run_op(1, 4'b0111, 64'h8000_0000, 64'd31, 64'hFFFF_FFFF, 1'b0, "sra31_s8");
    run_op(1, 4'b0110, 64'hF000_0000, 64'd9, 64'h0078_0000, 1'b0, "srl9_s8");
    run_rand(1, 6);

    run_op(2, 4'b0110, 64'h8000_0000_0000_0000, 64'd63, 64'h1, 1'b0, "srl63_x64");
    run_op(2, 4'b0101, 64'h0123_4567_89AB_CDEF, 64'h40, 64'h0123_4567_89AB_CDEF, 1'b0,
           "sll0_x64");
    run_rand(2, 4);

    // Reset in the middle of an SLL by 20 must drop it with no output.
    run_op(0, 4'b1010, 64'h0, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 1'b0, "pass_b");
    @(negedge clk);
    op_d    = 4'b0101;
    a_d     = 64'h0000_0001;
    b_d     = 64'd20;
    iv[0]   = 1'b1;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midrst.in_ready", 64'(ir[0]), 64'd1);
    check_eq("midrst.out_valid", 64'(ov[0]), 64'd0);
    check_eq("midrst.busy", 64'(bz[0]), 64'd0);
    check_eq("midrst.result", res_m[0], 64'd0);
    @(negedge clk);
    reset = 1'b0;
    stale = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ov[0]) stale++;
    end
    check_eq("midrst.no_stale", 64'(stale), 64'd0);
    check_eq("midrst.result_held", res_m[0], 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
